// File: rtl/spi_slave_responder.sv
// spi_slave_responder
//   SPI slave end of the link. sclk, ss and mosi are oversampled on clk
//   (clk must run at least 8x the sclk rate). Words of DATA_W bits are
//   received MSB-first on mosi. Words are returned on miso from a one-entry
//   transmit holding buffer. All four CPOL/CPHA modes are set by parameters.
//
//   Handshake (tx side): a word moves into the holding buffer on any clk where
//   tx_valid && tx_ready. tx_ready is high exactly while the buffer is empty.
//   The buffer is emptied when a word starts: either ss falls, or the last bit
//   of the previous word is sampled. rx_valid is a 1-clk strobe, with no back-pressure.
//
//   Optional feature: define SPI_SLAVE_RESPONDER_ERR_EN to add the tx_underrun
//   and frame_abort pulse outputs.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   sclk, ss, mosi  asynchronous SPI pins (ss active low)
//   miso, miso_oe   slave data out and its pad enable
//   tx_data/valid   word offered to the holding buffer; tx_ready = buffer empty
//   rx_data/valid   last complete received word, 1-clk strobe on update
//   busy            frame in progress (FSM in ACTIVE)
//   tx_underrun     (ERR_EN) a word started with the buffer empty
//   frame_abort     (ERR_EN) ss rose in the middle of a word
module spi_slave_responder #(
    parameter int                CLK_POLARITY = 0,
    parameter int                CLK_PHASE    = 0,
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] IDLE_TX      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
    ,
    output logic              tx_underrun,
    output logic              frame_abort
`endif
);

    localparam int   CNT_W     = $clog2(DATA_W + 1);
    localparam logic SCLK_IDLE = (CLK_POLARITY != 0);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    // Synchronizers (two stages) plus one history stage for edge detect.
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic ss_s1_q, ss_s2_q, ss_h_q;
    logic mosi_s1_q, mosi_s2_q;

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0]  tx_shift_q;
    logic [DATA_W-2:0]  rx_shift_q;
    logic [DATA_W-1:0]  rx_data_q;
    logic               rx_valid_q;
    logic [DATA_W-1:0]  buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
    logic               underrun_q, abort_q, underrun_pend_q;
`endif

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, change_edge;
    logic ss_fall, ss_rise, last_bit, word_load, accept;
    logic [DATA_W-1:0] load_word, rx_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q <= SCLK_IDLE;
            sclk_s2_q <= SCLK_IDLE;
            sclk_h_q  <= SCLK_IDLE;
            // ss stages clear to low so that a frame already running when reset
            // releases never looks like a falling edge; a real high->low is needed.
            ss_s1_q   <= 1'b0;
            ss_s2_q   <= 1'b0;
            ss_h_q    <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            ss_s1_q   <= ss;
            ss_s2_q   <= ss_s1_q;
            ss_h_q    <= ss_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    always_comb begin
        sclk_rise   = sclk_s2_q & ~sclk_h_q;
        sclk_fall   = ~sclk_s2_q & sclk_h_q;
        lead_edge   = (CLK_POLARITY == 0) ? sclk_rise : sclk_fall;
        trail_edge  = (CLK_POLARITY == 0) ? sclk_fall : sclk_rise;
        sample_edge = (CLK_PHASE == 0) ? lead_edge : trail_edge;
        change_edge = (CLK_PHASE == 0) ? trail_edge : lead_edge;
        ss_fall     = ~ss_s2_q & ss_h_q;
        ss_rise     = ss_s2_q & ~ss_h_q;
        last_bit    = (bit_cnt_q == CNT_W'(DATA_W - 1));
        rx_word     = {rx_shift_q, mosi_s2_q};
        load_word   = buf_full_q ? buf_q : IDLE_TX;
        word_load   = ((state_q == ST_IDLE) && ss_fall) ||
                      ((state_q == ST_ACTIVE) && !ss_rise && sample_edge && last_bit);
        accept      = tx_valid && !buf_full_q;
    end

    // Holding buffer: a load empties it, and a same-clk accept keeps it full.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (word_load && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    // Main FSM.
    // A change edge shifts only when bit_cnt != 0. Two cases follow from this:
    //   CPHA=1: the first leading edge of a word does not shift.
    //   CPHA=0: the trailing edge after a word's last sample does not shift,
    //           because the reload has already put the next MSB in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            tx_shift_q      <= '0;
            rx_shift_q      <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
            underrun_q      <= 1'b0;
            abort_q         <= 1'b0;
            underrun_pend_q <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_q    <= ST_ACTIVE;
                        bit_cnt_q  <= '0;
                        tx_shift_q <= load_word;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
                        underrun_q      <= !buf_full_q;
                        underrun_pend_q <= 1'b0;
`endif
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
                        abort_q         <= (bit_cnt_q != '0);
                        underrun_pend_q <= 1'b0;
`endif
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_word[DATA_W-2:0];
                            if (last_bit) begin
                                rx_data_q  <= rx_word;
                                rx_valid_q <= 1'b1;
                                bit_cnt_q  <= '0;
                                tx_shift_q <= load_word;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
                                // An empty reload is reported only when the next
                                // word really starts clocking.
                                underrun_pend_q <= !buf_full_q;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else if (change_edge && (bit_cnt_q != '0)) begin
                            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                        end
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
                        if (underrun_pend_q && lead_edge) begin
                            underrun_q      <= 1'b1;
                            underrun_pend_q <= 1'b0;
                        end
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ST_ACTIVE);
    assign miso_oe  = busy;
    assign miso     = busy ? tx_shift_q[DATA_W-1] : 1'b0;
    assign tx_ready = !buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
    assign tx_underrun = underrun_q;
    assign frame_abort = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder. Two instances share ss, mosi and the tx
// interface: one runs mode 0 and one runs mode 3. Each has its own sclk, and
// the two sclk waveforms differ only in idle level. A frame-level model
// predicts the words the master reads and the words the slave must report.
module tb_spi_slave_responder;

    localparam int          W       = 16;
    localparam int          H       = 25;   // sclk half period in clk (1 MHz at 50 MHz)
    localparam logic [W-1:0] IDLE_TX = 16'h0000;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic         rst, ss, mosi, sclk0, sclk3, tx_valid;
    logic [W-1:0] tx_data;
    logic         miso0, miso_oe0, tx_ready0, rx_valid0, busy0;
    logic         miso3, miso_oe3, tx_ready3, rx_valid3, busy3;
    logic [W-1:0] rx_data0, rx_data3;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
    logic         underrun0, abort0, underrun3, abort3;
`endif

    spi_slave_responder #(.CLK_POLARITY(0), .CLK_PHASE(0), .DATA_W(W), .IDLE_TX(IDLE_TX)) u_dut0 (
        .clk(clk), .rst(rst), .sclk(sclk0), .ss(ss), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0)
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
        , .tx_underrun(underrun0), .frame_abort(abort0)
`endif
    );

    spi_slave_responder #(.CLK_POLARITY(1), .CLK_PHASE(1), .DATA_W(W), .IDLE_TX(IDLE_TX)) u_dut3 (
        .clk(clk), .rst(rst), .sclk(sclk3), .ss(ss), .mosi(mosi),
        .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3), .busy(busy3)
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
        , .tx_underrun(underrun3), .frame_abort(abort3)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Model state
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q3[$];
    logic [W-1:0] txq[$];
    logic [W-1:0] cur_tx;
    logic         cur_empty;
    int rx_cnt0 = 0, rx_cnt3 = 0;
    int unr_cnt0 = 0, unr_cnt3 = 0, abt_cnt0 = 0, abt_cnt3 = 0;
    int exp_unr = 0, exp_abort = 0;
    int unstable = 0;
    logic rxv_prev0 = 1'b0, rxv_prev3 = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle checks against the model
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            rxv_prev0 = 1'b0;
            rxv_prev3 = 1'b0;
        end else begin
            check("oe0_vs_busy", miso_oe0, busy0);
            check("oe3_vs_busy", miso_oe3, busy3);
            if (!busy0) check("idle_miso0", miso0, 1'b0);
            if (!busy3) check("idle_miso3", miso3, 1'b0);
            check("rx_pulse0", rxv_prev0 & rx_valid0, 1'b0);
            check("rx_pulse3", rxv_prev3 & rx_valid3, 1'b0);
            if (rx_valid0) begin
                rx_cnt0++;
                if (exp_q0.size() == 0) check("rx0_unexpected", rx_valid0, 1'b0);
                else check("rx_data0", rx_data0, exp_q0.pop_front());
            end
            if (rx_valid3) begin
                rx_cnt3++;
                if (exp_q3.size() == 0) check("rx3_unexpected", rx_valid3, 1'b0);
                else check("rx_data3", rx_data3, exp_q3.pop_front());
            end
            rxv_prev0 = rx_valid0;
            rxv_prev3 = rx_valid3;
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
            if (underrun0) unr_cnt0++;
            if (underrun3) unr_cnt3++;
            if (abort0) abt_cnt0++;
            if (abort3) abt_cnt3++;
`endif
        end
    end

    function automatic void model_pop();
        if (txq.size() > 0) begin
            cur_tx    = txq.pop_front();
            cur_empty = 1'b0;
        end else begin
            cur_tx    = IDLE_TX;
            cur_empty = 1'b1;
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!(tx_ready0 && tx_ready3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready0 & tx_ready3, 1'b1);
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        wait_ready();
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        txq.push_back(w);
        check("tx_ready_drop0", tx_ready0, 1'b0);
        check("tx_ready_drop3", tx_ready3, 1'b0);
    endtask

    task automatic spi_begin();
        sclk0 = 1'b0;
        sclk3 = 1'b1;
        ss    = 1'b0;
        model_pop();
        if (cur_empty) exp_unr++;
        repeat (H) @(negedge clk);
    endtask

    // One bit: both sclks go low (mode-3 leading edge), then rise (sample edge of both masters).
    task automatic spi_bit(input logic b, output logic m0, output logic m3);
        sclk0 = 1'b0;
        sclk3 = 1'b0;
        mosi  = b;
        repeat (H) @(negedge clk);
        m0    = miso0;
        m3    = miso3;
        sclk0 = 1'b1;
        sclk3 = 1'b1;
        repeat (2) @(negedge clk);
        if (miso0 !== m0 || miso3 !== m3) unstable++;
        repeat (H - 2) @(negedge clk);
    endtask

    task automatic spi_bits(input int n, input logic [W-1:0] d);
        logic m0, m3;
        for (int i = 0; i < n; i++) spi_bit(d[W-1-i], m0, m3);
    endtask

    task automatic spi_word(input logic [W-1:0] w, input bit first,
                            output logic [W-1:0] r0, output logic [W-1:0] r3);
        logic m0, m3;
        if (!first && cur_empty) exp_unr++;
        exp_q0.push_back(w);
        exp_q3.push_back(w);
        for (int i = 0; i < W; i++) begin
            spi_bit(w[W-1-i], m0, m3);
            r0[W-1-i] = m0;
            r3[W-1-i] = m3;
        end
        check("miso_word0", r0, cur_tx);
        check("miso_word3", r3, cur_tx);
        model_pop();
    endtask

    task automatic spi_end();
        sclk0 = 1'b0;
        sclk3 = 1'b1;
        repeat (H) @(negedge clk);
        ss = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso0"}, miso0, 1'b0);
        check({tag, "_oe0"}, miso_oe0, 1'b0);
        check({tag, "_txrdy0"}, tx_ready0, 1'b1);
        check({tag, "_rxdata0"}, rx_data0, 16'h0000);
        check({tag, "_rxv0"}, rx_valid0, 1'b0);
        check({tag, "_busy0"}, busy0, 1'b0);
        check({tag, "_miso3"}, miso3, 1'b0);
        check({tag, "_oe3"}, miso_oe3, 1'b0);
        check({tag, "_txrdy3"}, tx_ready3, 1'b1);
        check({tag, "_rxdata3"}, rx_data3, 16'h0000);
        check({tag, "_rxv3"}, rx_valid3, 1'b0);
        check({tag, "_busy3"}, busy3, 1'b0);
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
        check({tag, "_unr0"}, underrun0, 1'b0);
        check({tag, "_abt0"}, abort0, 1'b0);
        check({tag, "_unr3"}, underrun3, 1'b0);
        check({tag, "_abt3"}, abort3, 1'b0);
`endif
    endtask

    initial begin
        #5_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [W-1:0] r0, r3, r0b, r3b;
        int c0, c3, u0, u3;
        rst = 1'b1; ss = 1'b1; mosi = 1'b0; sclk0 = 1'b0; sclk3 = 1'b1;
        tx_valid = 1'b0; tx_data = '0;
        repeat (5) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Mode 0 / mode 3 single word
        push_tx(16'h1234);
        c0 = rx_cnt0; c3 = rx_cnt3;
        spi_begin();
        spi_word(16'hA5C3, 1'b1, r0, r3);
        spi_end();
        check("t1_read0", r0, 16'h1234);
        check("t1_read3", r3, 16'h1234);
        check("t1_rxcnt0", rx_cnt0 - c0, 1);
        check("t1_rxcnt3", rx_cnt3 - c3, 1);
        check("t1_rxdata0", rx_data0, 16'hA5C3);
        check("t1_rxdata3", rx_data3, 16'hA5C3);
        check("t1_txrdy0", tx_ready0, 1'b1);
        check("t1_txrdy3", tx_ready3, 1'b1);
        check("t1_busy0", busy0, 1'b0);

        // Back-to-back words in one ss-low window
        push_tx(16'h0F0F);
        c0 = rx_cnt0; c3 = rx_cnt3;
        spi_begin();
        fork
            spi_word(16'hBEEF, 1'b1, r0, r3);
            push_tx(16'hF0F0);
        join
        spi_word(16'hCAFE, 1'b0, r0b, r3b);
        spi_end();
        check("t2_read0a", r0, 16'h0F0F);
        check("t2_read3a", r3, 16'h0F0F);
        check("t2_read0b", r0b, 16'hF0F0);
        check("t2_read3b", r3b, 16'hF0F0);
        check("t2_rxcnt0", rx_cnt0 - c0, 2);
        check("t2_rxcnt3", rx_cnt3 - c3, 2);
        check("t2_rxdata0", rx_data0, 16'hCAFE);

        // Abort after 7 sample edges
        push_tx(16'h1357);
        c0 = rx_cnt0; c3 = rx_cnt3;
        spi_begin();
        spi_bits(7, 16'h5A5A);
        ss = 1'b1;
        exp_abort++;
        repeat (4) @(negedge clk);
        check("t3_busy0", busy0, 1'b0);
        check("t3_busy3", busy3, 1'b0);
        sclk0 = 1'b0;
        repeat (H) @(negedge clk);
        check("t3_rxcnt0", rx_cnt0 - c0, 0);
        check("t3_rxcnt3", rx_cnt3 - c3, 0);
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
        check("t3_abort0", abt_cnt0, 1);
        check("t3_abort3", abt_cnt3, 1);
`endif
        push_tx(16'h2468);
        spi_begin();
        spi_word(16'h5A5A, 1'b1, r0, r3);
        spi_end();
        check("t3_rxdata0", rx_data0, 16'h5A5A);
        check("t3_rxdata3", rx_data3, 16'h5A5A);
        check("t3_read0", r0, 16'h2468);

        // Empty buffer at frame start
        u0 = unr_cnt0; u3 = unr_cnt3;
        spi_begin();
        spi_word(16'h9669, 1'b1, r0, r3);
        spi_end();
        check("t4_read0", r0, 16'h0000);
        check("t4_read3", r3, 16'h0000);
        check("t4_rxdata0", rx_data0, 16'h9669);
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
        check("t4_unr_once0", unr_cnt0 - u0, 1);
        check("t4_unr_once3", unr_cnt3 - u3, 1);
`endif

        // Reset at bit 9 of a frame
        push_tx(16'h3C3C);
        c0 = rx_cnt0; c3 = rx_cnt3;
        spi_begin();
        spi_bits(9, 16'hFF00);
        push_tx(16'h7777);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        txq.delete();
        spi_bits(7, 16'h00FF);
        spi_end();
        check("t5_rxcnt0", rx_cnt0 - c0, 0);
        check("t5_rxcnt3", rx_cnt3 - c3, 0);
        check("t5_busy0", busy0, 1'b0);
        push_tx(16'h6006);
        spi_begin();
        spi_word(16'h8001, 1'b1, r0, r3);
        spi_end();
        check("t5_rxdata0", rx_data0, 16'h8001);
        check("t5_rxdata3", rx_data3, 16'h8001);
        check("t5_read3", r3, 16'h6006);

        // Final model reconciliation
        repeat (10) @(negedge clk);
        check("pending_rx0", exp_q0.size(), 0);
        check("pending_rx3", exp_q3.size(), 0);
        check("miso_stable", unstable, 0);
`ifdef SPI_SLAVE_RESPONDER_ERR_EN
        check("underrun_total0", unr_cnt0, exp_unr);
        check("underrun_total3", unr_cnt3, exp_unr);
        check("abort_total0", abt_cnt0, exp_abort);
        check("abort_total3", abt_cnt3, exp_abort);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
